rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  ALU results and load (MEM) results. Each source has its own valid/ready

---
 rtl/rf_arb_pkg.sv | 30 +++
 rtl/rf_wb_slot.sv | 67 ++++++
 rtl/rf_write_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Default widths here match the arbiter's default WIDTH/NREGS parameters.
package rf_arb_pkg;

  // Elaboration-time log2 for flows whose tools lack $clog2.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int RF_WIDTH = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = clog2(RF_NREGS);

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  typedef struct packed {
    logic [RF_AW-1:0]    addr;
    logic [RF_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot with a valid/ready handshake.
// ready_o is combinational from slot state and grant only, never from valid_i.
//
// state   | meaning
// S_EMPTY | no request held, ready to accept
// S_FULL  | request held, waiting for a grant from the arbiter
module rf_wb_slot
  import rf_arb_pkg::*;
#(
  parameter int AW    = 5,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             grant_i,
  output logic             ready_o,
  output logic             full_o,
  output logic [AW-1:0]    addr_o,
  output logic [WIDTH-1:0] data_o
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

  slot_state_t      state_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  assign ready_o = (state_q == S_EMPTY) | grant_i;
  assign accept  = valid_i & ready_o;
  assign full_o  = (state_q == S_FULL);
  assign addr_o  = addr_q;
  assign data_o  = data_q;

  // A grant and a new accept in the same cycle keep the slot FULL with fresh contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q <= S_FULL;
            addr_q  <= addr_i;
            data_q  <= data_i;
          end
        end
        S_FULL: begin
          if (accept) begin
            state_q <= S_FULL;
            addr_q  <= addr_i;
            data_q  <= data_i;
          end else if (grant_i) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Oldest-first arbiter sharing the reg_file write port between ALU and MEM writeback.
// Define RF_WR_PEND_EN to add the pend_mask pending-write output for the hazard unit.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW = clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_addr,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             idle
`ifdef RF_WR_PEND_EN
  ,
  output logic [NREGS-1:0] pend_mask
`endif
);

  logic             alu_full, mem_full;
  logic [AW-1:0]    alu_slot_addr, mem_slot_addr;
  logic [WIDTH-1:0] alu_slot_data, mem_slot_data;
  logic [1:0]       grant;
  logic             alu_load, mem_load;
  logic             alu_older_q, alu_older_d;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;

  rf_wb_slot #(.AW(AW), .WIDTH(WIDTH)) u_alu_slot (
    .clock   (clock),
    .reset   (reset),
    .valid_i (alu_valid),
    .addr_i  (alu_addr),
    .data_i  (alu_data),
    .grant_i (grant[SRC_ALU]),
    .ready_o (alu_ready),
    .full_o  (alu_full),
    .addr_o  (alu_slot_addr),
    .data_o  (alu_slot_data)
  );

  rf_wb_slot #(.AW(AW), .WIDTH(WIDTH)) u_mem_slot (
    .clock   (clock),
    .reset   (reset),
    .valid_i (mem_valid),
    .addr_i  (mem_addr),
    .data_i  (mem_data),
    .grant_i (grant[SRC_MEM]),
    .ready_o (mem_ready),
    .full_o  (mem_full),
    .addr_o  (mem_slot_addr),
    .data_o  (mem_slot_data)
  );

  assign alu_load = alu_valid & alu_ready;
  assign mem_load = mem_valid & mem_ready;

  // alu_older_q is only meaningful while both slots are FULL; a same-cycle load leaves MEM older.
  always_comb begin
    alu_older_d = alu_older_q;
    if (alu_load) begin
      alu_older_d = 1'b0;
    end else if (mem_load) begin
      alu_older_d = 1'b1;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (alu_full && mem_full) begin
      if (alu_older_q) begin
        grant[SRC_ALU] = 1'b1;
      end else begin
        grant[SRC_MEM] = 1'b1;
      end
    end else if (alu_full) begin
      grant[SRC_ALU] = 1'b1;
    end else if (mem_full) begin
      grant[SRC_MEM] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_older_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      alu_older_q <= alu_older_d;
      wr_en_q     <= |grant;
      if (grant[SRC_MEM]) begin
        wr_addr_q <= mem_slot_addr;
        wr_data_q <= mem_slot_data;
      end else if (grant[SRC_ALU]) begin
        wr_addr_q <= alu_slot_addr;
        wr_data_q <= alu_slot_data;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign idle    = ~alu_full & ~mem_full & ~wr_en_q;

`ifdef RF_WR_PEND_EN
  always_comb begin
    pend_mask = '0;
    if (alu_full) begin
      pend_mask[alu_slot_addr] = 1'b1;
    end
    if (mem_full) begin
      pend_mask[mem_slot_addr] = 1'b1;
    end
    if (wr_en_q) begin
      pend_mask[wr_addr_q] = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus random bench for rf_write_arbiter against a timestamp-ordered reference model.
// Define RF_WR_PEND_EN to also check pend_mask.
module tb_rf_write_arbiter;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             alu_valid = 1'b0;
  logic             alu_ready;
  logic [AW-1:0]    alu_addr = '0;
  logic [WIDTH-1:0] alu_data = '0;
  logic             mem_valid = 1'b0;
  logic             mem_ready;
  logic [AW-1:0]    mem_addr = '0;
  logic [WIDTH-1:0] mem_data = '0;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             idle;
`ifdef RF_WR_PEND_EN
  logic [NREGS-1:0] pend_mask;
`endif

  always #5 clock = ~clock;

  rf_write_arbiter #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .idle      (idle)
`ifdef RF_WR_PEND_EN
    ,
    .pend_mask (pend_mask)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = ALU, 1 = MEM; each full slot carries its load cycle.
  bit               m_full [2];
  int               m_ts   [2];
  logic [AW-1:0]    m_addr [2];
  logic [WIDTH-1:0] m_data [2];
  logic             m_wen;
  logic [AW-1:0]    m_waddr;
  logic [WIDTH-1:0] m_wdata;
  int               cyc = 0;
  int               accepts = 0;
  int               writes_seen = 0;
  logic [WIDTH-1:0] rf_obs [NREGS];

  function automatic int model_grant();
    if (m_full[0] && m_full[1]) return (m_ts[1] <= m_ts[0]) ? 1 : 0;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_full[0] = 0; m_full[1] = 0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                      input logic mv, input logic [AW-1:0] ma, input logic [WIDTH-1:0] md);
    int   g;
    logic er_a, er_m;
`ifdef RF_WR_PEND_EN
    logic [NREGS-1:0] pe;
`endif
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    g    = model_grant();
    er_a = !m_full[0] || (g == 0);
    er_m = !m_full[1] || (g == 1);
    @(negedge clock);
    chk("alu_ready", alu_ready, er_a);
    chk("mem_ready", mem_ready, er_m);
    chk("wr_en", wr_en, m_wen);
    chk("wr_addr", wr_addr, m_waddr);
    chk("wr_data", wr_data, m_wdata);
    chk("idle", idle, !m_full[0] && !m_full[1] && !m_wen);
`ifdef RF_WR_PEND_EN
    pe = '0;
    if (m_full[0]) pe[m_addr[0]] = 1'b1;
    if (m_full[1]) pe[m_addr[1]] = 1'b1;
    if (m_wen) pe[m_waddr] = 1'b1;
    chk("pend_mask", pend_mask, pe);
`endif
    if (wr_en === 1'b1) begin
      rf_obs[wr_addr] = wr_data;
      writes_seen++;
    end
    @(posedge clock);
    m_wen = (g >= 0);
    if (g >= 0) begin
      m_waddr  = m_addr[g];
      m_wdata  = m_data[g];
      m_full[g] = 0;
    end
    if (av && er_a) begin
      m_full[0] = 1; m_ts[0] = cyc; m_addr[0] = aa; m_data[0] = ad; accepts++;
    end
    if (mv && er_m) begin
      m_full[1] = 1; m_ts[1] = cyc; m_addr[1] = ma; m_data[1] = md; accepts++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; released just after the following rising edge.
  task automatic do_reset();
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    #2;
    @(negedge clock);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int w0;
    for (int r = 0; r < NREGS; r++) rf_obs[r] = '0;
    model_clear();
    do_reset();

    // ALU alone, back to back to one address
    step(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
    step(1'b1, 5'd5, 32'h22, 1'b0, '0, '0);
    step(1'b1, 5'd5, 32'h33, 1'b0, '0, '0);
    idle_steps(3);
    chk("alu_seq_r5", rf_obs[5], 32'h33);

    // Same-cycle tie to one address: MEM first, ALU value survives
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    idle_steps(3);
    chk("tie_r3", rf_obs[3], 32'hA);

    // Age order with both slots busy: MEM 0x1 older than ALU 0x2
    step(1'b1, 5'd20, 32'hAAAA, 1'b1, 5'd21, 32'hBBBB);
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h1);
    step(1'b1, 5'd7, 32'h2, 1'b0, '0, '0);
    idle_steps(4);
    chk("age_r7", rf_obs[7], 32'h2);

    // Backpressure: both sources valid for 10 cycles
    w0 = writes_seen;
    for (int i = 0; i < 10; i++)
      step(1'b1, AW'($urandom), $urandom, 1'b1, AW'($urandom), $urandom);
    idle_steps(4);
    chk("bp_write_count", writes_seen - w0, 11);

    // Reset while both slots are full; no stale write may follow
    step(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF);
    step(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF);
    do_reset();
    idle_steps(3);

    // Single MEM write to register 9 behind ALU traffic
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
    step(1'b1, 5'd4, 32'h45, 1'b0, '0, '0);
    idle_steps(4);
    chk("r9_value", rf_obs[9], 32'h99);
`ifdef RF_WR_PEND_EN
    chk("pend_clear", pend_mask, '0);
`endif

    // Random traffic, including address 0
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
    idle_steps(4);
    chk("final_idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
